analogizer_csync_gen: RTL and testbench

- Conditions the core's raw video before it reaches the Analogizer analog output stage.
- Takes separate active-low HS/VS, DE and 6-bit RGB from the NeoGeo core and produces a registered composite sync (simple XNOR, serrated, or H-only), with delayed sync, DE and RGB aligned to it.
- Measures line length and HS width in pixel-enable units and asserts lock only when line timing is stable.
- Runs in the video clock domain, between the emu video outputs and the Analogizer R/G/B/BLANKn/Hsync inputs.

---
 rtl/analogizer_csync_gen.sv | 92 +++++++++
 tb/tb_analogizer_csync_gen.sv | 108 ++++++++++
 2 files changed

// File: rtl/analogizer_csync_gen.sv
// analogizer_csync_gen: composite sync generator with 2-ce_pix aligned video pipeline and line-lock detect
// clk_vid/reset_l: video clock, async active-low reset; ce_pix: pixel enable
// hs_in/vs_in (active low), de_in, r_in/g_in/b_in: raw core video
// csync_mode: 0 xnor, 1 serrated, 2 hs only, 3 as 0
// csync_n, hs_out, vs_out, de_out, r_out/g_out/b_out: video delayed 2 ce_pix
// line_len: last measured line length; locked: line timing stable
module analogizer_csync_gen #(
  parameter int CNT_W    = 12,
  parameter int RGB_W    = 6,
  parameter int MIN_LINE = 64
) (
  input  logic             clk_vid,
  input  logic             reset_l,
  input  logic             ce_pix,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic             de_in,
  input  logic [RGB_W-1:0] r_in,
  input  logic [RGB_W-1:0] g_in,
  input  logic [RGB_W-1:0] b_in,
  input  logic [1:0]       csync_mode,
  output logic             csync_n,
  output logic             hs_out,
  output logic             vs_out,
  output logic             de_out,
  output logic [RGB_W-1:0] r_out,
  output logic [RGB_W-1:0] g_out,
  output logic [RGB_W-1:0] b_out,
  output logic [CNT_W-1:0] line_len,
  output logic             locked
);
  localparam int PW = 3 + 3 * RGB_W;
  localparam logic [CNT_W-1:0] SAT   = '1;
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_L = CNT_W'(MIN_LINE);
  localparam logic [PW-1:0]    RST1  = {2'b11, (PW-2)'(0)};
  logic [PW-1:0]    p1_q, p1_d;
  logic [PW:0]      p2_q, p2_d;
  logic [CNT_W-1:0] pos_q, pos_d, hs_w_q, hs_w_d, line_len_q, line_len_d;
  logic [CNT_W-1:0] len, half;
  logic [1:0]       mode_q, mode_d;
  logic             seen_q, seen_d, locked_q, locked_d;
  logic             hs1, vs1, fall, rise, sat, in_win, xnor_s, csync_d;
  // pos_q is the position of the pixel currently held in stage 1
  always_comb begin
    hs1        = p1_q[PW-1];
    vs1        = p1_q[PW-2];
    fall       = hs1 & ~hs_in;
    rise       = ~hs1 & hs_in;
    sat        = pos_q == SAT;
    len        = sat ? SAT : pos_q + ONE;
    half       = line_len_q >> 1;
    in_win     = (pos_q >= half - hs_w_q && pos_q < half) ||
                 (pos_q >= line_len_q - hs_w_q && pos_q < line_len_q);
    xnor_s     = ~(hs1 ^ vs1);
    csync_d    = mode_q == 2'd2 ? hs1 :
                 (mode_q == 2'd1 && locked_q) ? (vs1 ? hs1 : (hs_w_q < half ? in_win : xnor_s)) :
                 xnor_s;
    p1_d       = {hs_in, vs_in, de_in, r_in, g_in, b_in};
    p2_d       = {csync_d, p1_q};
    pos_d      = fall ? '0 : sat ? pos_q : pos_q + ONE;
    hs_w_d     = rise ? len : (sat && !hs1) ? SAT : hs_w_q;
    mode_d     = fall ? (csync_mode == 2'd3 ? 2'd0 : csync_mode) : mode_q;
    seen_d     = seen_q | fall;
    // the first falling edge after reset only starts the count
    line_len_d = (fall && seen_q) ? len : line_len_q;
    locked_d   = (fall && seen_q) ? (len >= MIN_L && len == line_len_q) : sat ? 1'b0 : locked_q;
  end
  always_ff @(posedge clk_vid or negedge reset_l)
    if (!reset_l) begin
      p1_q       <= RST1;
      p2_q       <= {1'b1, RST1};
      pos_q      <= '0;
      hs_w_q     <= '0;
      line_len_q <= '0;
      mode_q     <= '0;
      seen_q     <= 1'b0;
      locked_q   <= 1'b0;
    end else if (ce_pix) begin
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      pos_q      <= pos_d;
      hs_w_q     <= hs_w_d;
      line_len_q <= line_len_d;
      mode_q     <= mode_d;
      seen_q     <= seen_d;
      locked_q   <= locked_d;
    end
  assign {csync_n, hs_out, vs_out, de_out, r_out, g_out, b_out} = p2_q;
  assign line_len = line_len_q;
  assign locked   = locked_q;
endmodule

// File: tb/tb_analogizer_csync_gen.sv
// tb_analogizer_csync_gen: scoreboard bench for analogizer_csync_gen
module tb_analogizer_csync_gen;
  logic        clk_vid = 0, reset_l = 0, ce_pix = 0, hs_in = 1, vs_in = 1, de_in = 0;
  logic [5:0]  r_in = 0, g_in = 0, b_in = 0;
  logic [1:0]  csync_mode = 0;
  logic        csync_n, hs_out, vs_out, de_out, locked;
  logic [5:0]  r_out, g_out, b_out;
  logic [11:0] line_len;
  typedef struct packed {logic cs; logic [20:0] v;} exp_t;
  exp_t q[$];
  int  checks = 0, failures = 0;
  bit  mon_en = 0;
  analogizer_csync_gen dut (
    .clk_vid(clk_vid), .reset_l(reset_l), .ce_pix(ce_pix), .hs_in(hs_in), .vs_in(vs_in),
    .de_in(de_in), .r_in(r_in), .g_in(g_in), .b_in(b_in), .csync_mode(csync_mode),
    .csync_n(csync_n), .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out),
    .r_out(r_out), .g_out(g_out), .b_out(b_out), .line_len(line_len), .locked(locked)
  );
  always #5 clk_vid = ~clk_vid;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] r);
    checks++;
    if (a !== r) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", n, a, r, $time);
    end
  endtask
  // outputs after the n-th ce_pix edge belong to pixel n-1
  always @(posedge clk_vid)
    if (mon_en && reset_l && ce_pix && q.size() >= 2) begin
      exp_t e;
      e = q.pop_front();
      #1;
      chk("csync", 32'(csync_n), 32'(e.cs));
      chk("video", 32'({hs_out, vs_out, de_out, r_out, g_out, b_out}), 32'(e.v));
    end
  task automatic pix(input logic h, v, d, input logic [5:0] r, g, b, input logic [1:0] m, input logic cs);
    @(negedge clk_vid);
    hs_in = h; vs_in = v; de_in = d; r_in = r; g_in = g; b_in = b; csync_mode = m; ce_pix = 1;
    q.push_back({cs, h, v, d, r, g, b});
    @(negedge clk_vid);
    ce_pix = 0;
  endtask
  task automatic send_line(input int len, w, input bit vsl, input int mst, mmid, meff, input bit lk, input int ll);
    for (int x = 0; x < len; x++) begin
      logic h, d, win, cs;
      h   = x >= w;
      d   = x >= w + 10 && x < len - 20;
      win = (x >= 192 - w && x < 192) || (x >= 384 - w && x < 384);
      cs  = meff == 2 ? h : (meff == 1 && lk && vsl) ? (w < 192 ? win : ~h) : (vsl ? ~h : h);
      pix(h, ~vsl, d, 6'(x), 6'(~x), 6'(x ^ 7), 2'(x < 100 ? mst : mmid), cs);
      if (x == 0 && ll >= 0) begin
        chk("locked", 32'(locked), 32'(lk));
        chk("line_len", 32'(line_len), ll);
      end
    end
  endtask
  task automatic chk_reset();
    chk("rst_csync", 32'(csync_n), 1);
    chk("rst_hs", 32'(hs_out), 1);
    chk("rst_vs", 32'(vs_out), 1);
    chk("rst_de", 32'(de_out), 0);
    chk("rst_rgb", 32'({r_out, g_out, b_out}), 0);
    chk("rst_len", 32'(line_len), 0);
    chk("rst_locked", 32'(locked), 0);
  endtask
  initial begin
    repeat (3) @(negedge clk_vid);
    reset_l = 1;
    repeat (4) @(negedge clk_vid);
    chk_reset();
    mon_en = 1;
    send_line(384, 29, 0, 0, 0, 0, 0, 0);
    send_line(384, 29, 0, 0, 0, 0, 0, 384);
    send_line(384, 29, 0, 0, 0, 0, 1, 384);
    repeat (3) send_line(384, 29, 1, 0, 0, 0, 1, 384);
    send_line(384, 29, 0, 0, 0, 0, 1, 384);
    send_line(384, 29, 0, 1, 1, 1, 1, 384);
    repeat (3) send_line(384, 29, 1, 1, 1, 1, 1, 384);
    send_line(384, 29, 0, 1, 1, 1, 1, 384);
    send_line(385, 29, 0, 1, 1, 1, 1, 384);
    send_line(384, 29, 1, 1, 1, 1, 0, 385);
    send_line(385, 29, 1, 1, 1, 1, 0, 384);
    send_line(384, 29, 0, 1, 1, 1, 0, 385);
    send_line(384, 29, 0, 1, 1, 1, 0, 384);
    send_line(384, 29, 1, 0, 1, 0, 1, 384);
    send_line(384, 29, 1, 1, 1, 1, 1, 384);
    send_line(384, 29, 0, 1, 1, 1, 1, 384);
    send_line(5000, 5000, 0, 1, 1, 1, 1, 384);
    chk("locked_sat", 32'(locked), 0);
    chk("len_sat", 32'(line_len), 384);
    @(negedge clk_vid);
    reset_l = 0;
    #1;
    chk_reset();
    q.delete();
    @(negedge clk_vid);
    reset_l = 1;
    send_line(63, 8, 0, 0, 0, 0, 0, 0);
    send_line(63, 8, 0, 0, 0, 0, 0, 63);
    send_line(63, 8, 0, 0, 0, 0, 0, 63);
    send_line(64, 8, 0, 0, 0, 0, 0, 63);
    send_line(64, 8, 0, 0, 0, 0, 0, 64);
    send_line(64, 8, 0, 0, 0, 0, 1, 64);
    repeat (4) @(negedge clk_vid);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
